// File: rtl/dram_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// dram_ctrl_fsm
//   Single-port DRAM command sequencer. It takes one word request at a time from
//   the AXI slave wrapper and turns it into PRECHARGE / ACTIVATE / READ / WRITE
//   pin cycles. Rows stay open between requests. Reads wait for DRAM_valid and
//   time out after RD_TIMEOUT cycles. Every accepted request produces exactly
//   one response.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. A producer holds valid and payload steady until that edge.
//   req_ready is high only in IDLE. rsp_valid/rsp_rdata/rsp_err stay steady
//   until rsp_ready is seen.
//
// Ports
//   dram_clk, dram_rst     clock (rising edge) and async active-low reset
//   req_*                  request channel (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                  response channel (valid/ready, rdata, err)
//   DRAM_CSn/RASn/CASn/WEn registered DRAM command pins
//   DRAM_A, DRAM_D         registered address / write data pins
//   DRAM_Q, DRAM_valid     read data return from the DRAM
//   dbg_state              current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module dram_ctrl_fsm #(
  parameter int T_RP       = 2,
  parameter int T_RCD      = 2,
  parameter int T_WR       = 2,
  parameter int RD_TIMEOUT = 63
) (
  input  logic        dram_clk,
  input  logic        dram_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid,
  output logic [3:0]  dbg_state
);

  localparam int MAX_A = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int MAX_B = (T_WR > RD_TIMEOUT) ? T_WR : RD_TIMEOUT;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAX_P) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT,
    S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          row_valid_q, row_valid_d;
  logic [10:0]   open_row_q, open_row_d;
  logic [10:0]   row_q, row_d;
  logic [9:0]    col_q, col_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          csn_q, csn_d, rasn_q, rasn_d, casn_q, casn_d;
  logic [3:0]    wen_q, wen_d;
  logic [10:0]   a_q, a_d;
  logic [31:0]   d_q, d_d;

  // Upper address bits and byte offset carry no meaning for this controller.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:23], req_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    row_valid_d = row_valid_q;
    open_row_d  = open_row_q;
    row_d       = row_q;
    col_d       = col_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          row_d   = req_addr[22:12];
          col_d   = req_addr[11:2];
          write_d = req_write;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_write && (req_wstrb == 4'h0)) begin
            // Nothing to write: answer straight away without touching the DRAM.
            state_d     = S_RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
          end else if (row_valid_q && (req_addr[22:12] == open_row_q)) begin
            state_d = req_write ? S_WR : S_RD;
          end else if (row_valid_q) begin
            state_d = S_PRE;
          end else begin
            state_d = S_ACT;
          end
        end
      end
      S_PRE: begin
        row_valid_d = 1'b0;
        if (T_RP > 1) begin
          state_d = S_PRE_WAIT;
          timer_d = TW'(T_RP - 2);
        end else begin
          state_d = S_ACT;
        end
      end
      S_PRE_WAIT: begin
        if (timer_q == '0) state_d = S_ACT;
        else               timer_d = timer_q - TW'(1);
      end
      S_ACT: begin
        row_valid_d = 1'b1;
        open_row_d  = row_q;
        if (T_RCD > 1) begin
          state_d = S_ACT_WAIT;
          timer_d = TW'(T_RCD - 2);
        end else begin
          state_d = write_q ? S_WR : S_RD;
        end
      end
      S_ACT_WAIT: begin
        if (timer_q == '0) state_d = write_q ? S_WR : S_RD;
        else               timer_d = timer_q - TW'(1);
      end
      S_RD: begin
        state_d = S_RD_WAIT;
        timer_d = TW'(RD_TIMEOUT - 1);
      end
      S_RD_WAIT: begin
        // Data arriving in the last wait cycle still wins over the timeout.
        if (DRAM_valid) begin
          state_d     = S_RESP;
          rsp_rdata_d = DRAM_Q;
          rsp_err_d   = 1'b0;
        end else if (timer_q == '0) begin
          // The row state is unknown after a lost read, so force a fresh ACT.
          state_d     = S_RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          row_valid_d = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WR: begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (T_WR > 1) begin
          state_d = S_WR_WAIT;
          timer_d = TW'(T_WR - 2);
        end else begin
          state_d = S_RESP;
        end
      end
      S_WR_WAIT: begin
        if (timer_q == '0) state_d = S_RESP;
        else               timer_d = timer_q - TW'(1);
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from the state being entered, so a command shows up
    // in the first cycle of its state. A and D hold between commands.
    csn_d  = 1'b1;
    rasn_d = 1'b1;
    casn_d = 1'b1;
    wen_d  = 4'hF;
    a_d    = a_q;
    d_d    = d_q;
    case (state_d)
      S_PRE: begin
        csn_d  = 1'b0;
        rasn_d = 1'b0;
        wen_d  = 4'h0;
      end
      S_ACT: begin
        csn_d  = 1'b0;
        rasn_d = 1'b0;
        a_d    = row_d;
      end
      S_RD: begin
        csn_d  = 1'b0;
        casn_d = 1'b0;
        a_d    = {1'b0, col_d};
      end
      S_WR: begin
        csn_d  = 1'b0;
        casn_d = 1'b0;
        wen_d  = ~wstrb_d;
        a_d    = {1'b0, col_d};
        d_d    = wdata_d;
      end
      default: ;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge dram_clk or negedge dram_rst) begin
    if (!dram_rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      row_valid_q <= 1'b0;
      open_row_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      csn_q       <= 1'b1;
      rasn_q      <= 1'b1;
      casn_q      <= 1'b1;
      wen_q       <= 4'hF;
      a_q         <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      row_valid_q <= row_valid_d;
      open_row_q  <= open_row_d;
      row_q       <= row_d;
      col_q       <= col_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      csn_q       <= csn_d;
      rasn_q      <= rasn_d;
      casn_q      <= casn_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      d_q         <= d_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign DRAM_CSn  = csn_q;
  assign DRAM_RASn = rasn_q;
  assign DRAM_CASn = casn_q;
  assign DRAM_WEn  = wen_q;
  assign DRAM_A    = a_q;
  assign DRAM_D    = d_q;
  assign dbg_state = state_q;

endmodule
